// File: rtl/dpll_lock_detector_if.sv
// Signal bundle between the DPLL lock monitor and its surroundings.
//
// Handshake: errValid is a one-cycle qualifier for phaseErr (and for the
// locked/dbg_state values that changed with it). There is no ready; the
// consumer must sample phaseErr in the cycle errValid is high. locked,
// refLost and dbg_state are levels and may be sampled at any time.
interface dpll_lock_detector_if #(
  parameter int CNT_W = 16
);
  logic             refIn;
  logic             fbIn;
  logic [CNT_W-1:0] errThreshold;
  logic [CNT_W-1:0] phaseErr;
  logic             errValid;
  logic             locked;
  logic             refLost;
  logic [1:0]       dbg_state;

  // Environment side: drives the clocks under test and the threshold.
  modport master (
    output refIn, fbIn, errThreshold,
    input  phaseErr, errValid, locked, refLost, dbg_state
  );

  // Detector side.
  modport slave (
    input  refIn, fbIn, errThreshold,
    output phaseErr, errValid, locked, refLost, dbg_state
  );
endinterface

// File: rtl/dpll_lock_detector.sv
// Lock-quality monitor for a DPLL with an XOR phase detector. Measures the
// XOR duty error over each reference period, runs a hysteretic lock FSM and
// raises an alarm when the reference stops toggling.
module dpll_lock_detector #(
  parameter int               CNT_W        = 16,
  parameter int               LOCK_COUNT   = 8,
  parameter int               UNLOCK_COUNT = 4,
  parameter logic [CNT_W-1:0] TIMEOUT      = {CNT_W{1'b1}}
) (
  input logic                  clk,
  input logic                  reset,
  dpll_lock_detector_if.slave  bus
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_ACQUIRE  = 2'd1,
    S_LOCKED   = 2'd2,
    S_HOLD     = 2'd3
  } state_t;

  // Synchroniser flops; ref has an extra stage for edge detection.
  logic ref_s1, ref_s2, ref_s3;
  logic fb_s1, fb_s2;
  logic ref_rise;
  logic xor_s;

  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] xor_cnt;

  logic signed [CNT_W+1:0] diff;
  logic signed [CNT_W+1:0] mag;
  logic [CNT_W-1:0]        err_sat;
  logic                    good;

  state_t           state;
  logic [GW-1:0]    good_cnt;
  logic [BW-1:0]    bad_cnt;
  logic             armed;
  logic [CNT_W-1:0] phase_err;
  logic             err_valid;
  logic             locked;
  logic             ref_lost;

  // Two-flop synchronisers for both inputs, third ref stage for the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_s1 <= 1'b0;
      ref_s2 <= 1'b0;
      ref_s3 <= 1'b0;
      fb_s1  <= 1'b0;
      fb_s2  <= 1'b0;
    end else begin
      ref_s1 <= bus.refIn;
      ref_s2 <= ref_s1;
      ref_s3 <= ref_s2;
      fb_s1  <= bus.fbIn;
      fb_s2  <= fb_s1;
    end
  end

  // Both paths see the same latency, so relative phase survives the sync.
  assign ref_rise = ref_s2 & ~ref_s3;
  assign xor_s    = ref_s2 ^ fb_s2;

  // Period and XOR-high counters; restart on each reference edge, saturate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
      xor_cnt    <= '0;
    end else if (ref_rise) begin
      period_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      xor_cnt    <= {{(CNT_W-1){1'b0}}, xor_s};
    end else begin
      if (period_cnt != {CNT_W{1'b1}})
        period_cnt <= period_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (xor_cnt != {CNT_W{1'b1}})
        xor_cnt <= xor_cnt + {{(CNT_W-1){1'b0}}, xor_s};
    end
  end

  // |2*xor - period| in two extra bits, then clamp to the output width.
  // The counts sampled on the edge cycle cover exactly one full period.
  assign diff    = $signed({1'b0, xor_cnt, 1'b0}) - $signed({2'b00, period_cnt});
  assign mag     = diff[CNT_W+1] ? -diff : diff;
  assign err_sat = (mag[CNT_W+1:CNT_W] != 2'b00) ? {CNT_W{1'b1}} : mag[CNT_W-1:0];
  assign good    = (err_sat <= bus.errThreshold);

  // Measurement capture, hysteretic lock FSM and reference-loss timeout.
  // The first edge after reset or timeout only arms; a coinciding edge
  // beats the timeout because it proves the reference is still alive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_UNLOCKED;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      armed     <= 1'b0;
      phase_err <= '0;
      err_valid <= 1'b0;
      locked    <= 1'b0;
      ref_lost  <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      if (ref_rise) begin
        ref_lost <= 1'b0;
        armed    <= 1'b1;
        if (armed) begin
          err_valid <= 1'b1;
          phase_err <= err_sat;
          case (state)
            S_UNLOCKED: begin
              if (good) begin
                if (LOCK_COUNT == 1) begin
                  state    <= S_LOCKED;
                  locked   <= 1'b1;
                  good_cnt <= '0;
                end else begin
                  state    <= S_ACQUIRE;
                  good_cnt <= GW'(1);
                end
              end
            end
            S_ACQUIRE: begin
              if (good) begin
                if (int'(good_cnt) + 1 >= LOCK_COUNT) begin
                  state    <= S_LOCKED;
                  locked   <= 1'b1;
                  good_cnt <= '0;
                end else begin
                  good_cnt <= good_cnt + GW'(1);
                end
              end else begin
                state    <= S_UNLOCKED;
                good_cnt <= '0;
              end
            end
            S_LOCKED: begin
              if (!good) begin
                if (UNLOCK_COUNT == 1) begin
                  state   <= S_UNLOCKED;
                  locked  <= 1'b0;
                  bad_cnt <= '0;
                end else begin
                  state   <= S_HOLD;
                  bad_cnt <= BW'(1);
                end
              end
            end
            S_HOLD: begin
              if (!good) begin
                if (int'(bad_cnt) + 1 >= UNLOCK_COUNT) begin
                  state   <= S_UNLOCKED;
                  locked  <= 1'b0;
                  bad_cnt <= '0;
                end else begin
                  bad_cnt <= bad_cnt + BW'(1);
                end
              end else begin
                state   <= S_LOCKED;
                bad_cnt <= '0;
              end
            end
            default: begin
              state    <= S_UNLOCKED;
              locked   <= 1'b0;
              good_cnt <= '0;
              bad_cnt  <= '0;
            end
          endcase
        end
      end else if (period_cnt == TIMEOUT) begin
        ref_lost <= 1'b1;
        state    <= S_UNLOCKED;
        locked   <= 1'b0;
        good_cnt <= '0;
        bad_cnt  <= '0;
        armed    <= 1'b0;
      end
    end
  end

  assign bus.phaseErr  = phase_err;
  assign bus.errValid  = err_valid;
  assign bus.locked    = locked;
  assign bus.refLost   = ref_lost;
  assign bus.dbg_state = state;

endmodule

// File: doc/dpll_lock_detector.md
# dpll_lock_detector

Lock-quality monitor that sits directly downstream of the DPLL. It observes the reference clock and the DPLL feedback output, and measures the XOR phase-detector duty error over each reference period. It then runs a hysteretic lock state machine. Outputs are a `locked` flag, a per-period phase-error measurement, and a reference-loss alarm, all in the system clock domain.

## Interface
- `CNT_W`, 16: width of the period, XOR and error counters.
- `LOCK_COUNT`, 8: consecutive good periods required to declare lock (≥1).
- `UNLOCK_COUNT`, 4: consecutive bad periods required to drop lock (≥1).
- `TIMEOUT`, 16'hFFFF: clk cycles without a reference edge before `refLost` asserts (≤ 2^CNT_W−1).

Ports:
- `clk` in 1: system clock (`sysClk` domain).
- `reset` in 1: asynchronous, active-high reset.
- `refIn` in 1: reference clock (`baseClockInput`); asynchronous to `clk`.
- `fbIn` in 1: DPLL output (`dpllOutput`); asynchronous to `clk`.
- `errThreshold` in CNT_W: maximum error counted as a good period; quasi-static.
- `phaseErr` out CNT_W: |2·xorHigh − period| of the last completed period, saturated.
- `errValid` out 1: one-cycle pulse when `phaseErr` updates.
- `locked` out 1: lock indication.
- `refLost` out 1: reference timeout alarm.

## Operation
- **Input synchronisation:** `refIn` and `fbIn` each pass through two flops. A third flop on ref gives `refRise` = s2 & ~s3. `xorS` = refS2 ^ fbS2.
- **Counters:** `periodCnt` and `xorCnt` saturate at all-ones.
  - On a `refRise` cycle: `periodCnt` ← 1, `xorCnt` ← xorS.
  - Otherwise: `periodCnt` += 1, and `xorCnt` += xorS.
  - Values captured at `refRise` are the pre-load values, equal to the exact period in clk cycles.
- **Error computation:** err = |2·xorCnt − periodCnt|, computed in CNT_W+2 signed bits and saturated to CNT_W. A good period is err ≤ `errThreshold`. A locked XOR PD (90° offset) gives err ≈ 0.
- **Measurement validity:** a measurement is valid only if a previous `refRise` was seen since reset or since the last timeout. The first edge after reset or timeout only arms counting; it produces no `errValid` and no FSM step.
- **Lock FSM** (steps only on a valid `refRise`):
  - UNLOCKED: good → ACQUIRE with goodCnt=1, or directly LOCKED if LOCK_COUNT=1. Bad → stay.
  - ACQUIRE: good → goodCnt+1, entering LOCKED when it reaches LOCK_COUNT. Bad → UNLOCKED, goodCnt=0.
  - LOCKED: bad → HOLD with badCnt=1, or UNLOCKED if UNLOCK_COUNT=1. Good → stay.
  - HOLD: bad → badCnt+1, entering UNLOCKED at UNLOCK_COUNT. Good → LOCKED, badCnt=0.
  - `locked` = 1 in LOCKED and HOLD.
- **Timeout:** when `periodCnt` reaches TIMEOUT with no `refRise`:
  - `refLost` ← 1, state ← UNLOCKED, good/bad counts ← 0, validity disarmed.
  - Counters keep saturating.
  - `refLost` clears on the next `refRise`; that edge re-arms validity only.
  - If timeout and `refRise` coincide, the `refRise` wins and the period is treated as valid. This can only occur when TIMEOUT equals the exact period.
- **Reset (any time, mid-period included):** all state is cleared. `phaseErr`=0, `errValid`=0, `locked`=0, `refLost`=0, FSM=UNLOCKED, validity disarmed.

## Timing
- `refIn` edge to `refRise`: 2–3 clk cycles. `fbIn` has identical latency, so relative phase is preserved to ±1 cycle.
- `refRise` in cycle E: `phaseErr`, `errValid`=1, FSM state and `locked` are all visible in cycle E+1. `errValid` is exactly one cycle wide.
- `refLost` asserts in the cycle after `periodCnt` == TIMEOUT. `locked` falls in the same cycle.
- Lock declared at the LOCK_COUNT-th consecutive valid good edge + 1 cycle. Unlock at the UNLOCK_COUNT-th consecutive bad edge + 1 cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- **Lock acquisition:** ref period 40 clk, fb same frequency at 90° (XOR high 20), threshold 2 → first edge no `errValid`; each later edge `phaseErr`=0; `locked` rises 1 cycle after the 8th valid edge.
- **Hysteresis:** when locked, shift fb to 0° (XOR high 0, err 40) for 3 periods, then restore → `locked` stays 1. Repeat with 4 bad periods → `locked` falls after the 4th.
- **Acquire abort:** 5 good periods, then 1 bad, then good → goodCnt restarts; lock only after 8 further good periods.
- **Reference loss:** TIMEOUT=100, stop ref while locked → `refLost`=1 and `locked`=0 at cycle 101 after the last edge. Restart ref → `refLost` clears at first edge, no `errValid` there, `errValid` on the second edge.
- **Saturation / threshold boundary:** fb stuck high (XOR = ~ref, high 20 of 40) → err 0. Separately, err exactly equal to the threshold counts as good, and threshold+1 counts as bad.
- **Reset mid-operation:** assert `reset` while in HOLD, mid-period → all outputs 0 immediately (async). After release, the first edge does not produce `errValid`.
